// File: rtl/sys_bus_arbiter_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
// Holds FSM state encodings, master indices, counter widths and the grant helper.
package sys_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic MST_0 = 1'b0;
    localparam logic MST_1 = 1'b1;

    localparam int unsigned WD_W     = 16;
    localparam int unsigned TO_CNT_W = 8;

    // Round-robin pick: alternate away from the last grant when both wait.
    function automatic logic rr_pick(input logic pend0, input logic pend1, input logic last);
        return (pend0 && pend1) ? ~last : pend1;
    endfunction

endpackage

// File: rtl/sys_bus_req_latch.sv
// Per-master request holding register: captures a single-cycle wen/ren pulse
// and keeps it pending until the arbiter completes it.
module sys_bus_req_latch #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic            wen_i,
    input  logic            ren_i,
    input  logic            clr_i,
    output logic            pend_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   wdata_o,
    output logic [DW/8-1:0] sel_o,
    output logic            wr_o
);

    logic            pend_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] sel_q;
    logic            wr_q;
    logic            accept_c;

    // A pulse is taken when idle, or in the completion cycle (set beats clear).
    assign accept_c = (wen_i || ren_i) && (!pend_q || clr_i);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
        end else if (accept_c) begin
            pend_q  <= 1'b1;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            sel_q   <= sel_i;
            wr_q    <= wen_i;
        end else if (clr_i) begin
            pend_q  <= 1'b0;
        end
    end

    assign pend_o  = pend_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign sel_o   = sel_q;
    assign wr_o    = wr_q;

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin arbiter for the system bus with a slave-ack watchdog.
// Requests are latched per master and issued one at a time through IDLE/ISSUE/WAIT/DONE.
module sys_bus_arbiter
    import sys_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic                sys_clk_i,
    input  logic                sys_rstn_i,
    input  logic [AW-1:0]       m0_addr_i,
    input  logic [DW-1:0]       m0_wdata_i,
    input  logic [DW/8-1:0]     m0_sel_i,
    input  logic                m0_wen_i,
    input  logic                m0_ren_i,
    output logic [DW-1:0]       m0_rdata_o,
    output logic                m0_err_o,
    output logic                m0_ack_o,
    input  logic [AW-1:0]       m1_addr_i,
    input  logic [DW-1:0]       m1_wdata_i,
    input  logic [DW/8-1:0]     m1_sel_i,
    input  logic                m1_wen_i,
    input  logic                m1_ren_i,
    output logic [DW-1:0]       m1_rdata_o,
    output logic                m1_err_o,
    output logic                m1_ack_o,
    output logic [AW-1:0]       sys_addr_o,
    output logic [DW-1:0]       sys_wdata_o,
    output logic [DW/8-1:0]     sys_sel_o,
    output logic                sys_wen_o,
    output logic                sys_ren_o,
    input  logic [DW-1:0]       sys_rdata_i,
    input  logic                sys_err_i,
    input  logic                sys_ack_i,
    output logic [TO_CNT_W-1:0] to_cnt_o
);

    localparam int unsigned SW = DW / 8;

    arb_state_e          state_q;
    logic                gnt_q;
    logic                last_q;
    logic [WD_W-1:0]     wd_cnt_q;
    logic [TO_CNT_W-1:0] to_cnt_q;

    logic          pend0, pend1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [SW-1:0] sel0, sel1;

    logic          clr0_c, clr1_c, gnt_c, busy_c, timeout_c, fire_c, rsp_err_c;
    logic [DW-1:0] rsp_rdata_c;

    assign clr0_c = (state_q == ST_DONE) && (gnt_q == MST_0);
    assign clr1_c = (state_q == ST_DONE) && (gnt_q == MST_1);

    sys_bus_req_latch #(.AW(AW), .DW(DW)) u_req0 (
        .clk_i   (sys_clk_i),
        .rstn_i  (sys_rstn_i),
        .addr_i  (m0_addr_i),
        .wdata_i (m0_wdata_i),
        .sel_i   (m0_sel_i),
        .wen_i   (m0_wen_i),
        .ren_i   (m0_ren_i),
        .clr_i   (clr0_c),
        .pend_o  (pend0),
        .addr_o  (addr0),
        .wdata_o (wdata0),
        .sel_o   (sel0),
        .wr_o    (wr0)
    );

    sys_bus_req_latch #(.AW(AW), .DW(DW)) u_req1 (
        .clk_i   (sys_clk_i),
        .rstn_i  (sys_rstn_i),
        .addr_i  (m1_addr_i),
        .wdata_i (m1_wdata_i),
        .sel_i   (m1_sel_i),
        .wen_i   (m1_wen_i),
        .ren_i   (m1_ren_i),
        .clr_i   (clr1_c),
        .pend_o  (pend1),
        .addr_o  (addr1),
        .wdata_o (wdata1),
        .sel_o   (sel1),
        .wr_o    (wr1)
    );

    // Watchdog counts WAIT cycles; a slave ack on the final cycle still wins.
    assign gnt_c       = rr_pick(pend0, pend1, last_q);
    assign busy_c      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign timeout_c   = (state_q == ST_WAIT) && !sys_ack_i
                         && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
    assign fire_c      = (busy_c && sys_ack_i) || timeout_c;
    assign rsp_rdata_c = timeout_c ? '0 : sys_rdata_i;
    assign rsp_err_c   = timeout_c || sys_err_i;

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= MST_0;
            last_q      <= MST_1;
            wd_cnt_q    <= '0;
            to_cnt_q    <= '0;
            sys_addr_o  <= '0;
            sys_wdata_o <= '0;
            sys_sel_o   <= '0;
            sys_wen_o   <= 1'b0;
            sys_ren_o   <= 1'b0;
            m0_rdata_o  <= '0;
            m0_err_o    <= 1'b0;
            m0_ack_o    <= 1'b0;
            m1_rdata_o  <= '0;
            m1_err_o    <= 1'b0;
            m1_ack_o    <= 1'b0;
        end else begin
            sys_wen_o <= 1'b0;
            sys_ren_o <= 1'b0;
            m0_ack_o  <= 1'b0;
            m1_ack_o  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend0 || pend1) begin
                        gnt_q       <= gnt_c;
                        last_q      <= gnt_c;
                        wd_cnt_q    <= '0;
                        sys_addr_o  <= gnt_c ? addr1  : addr0;
                        sys_wdata_o <= gnt_c ? wdata1 : wdata0;
                        sys_sel_o   <= gnt_c ? sel1   : sel0;
                        sys_wen_o   <= gnt_c ? wr1    : wr0;
                        sys_ren_o   <= gnt_c ? ~wr1   : ~wr0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    wd_cnt_q <= (state_q == ST_ISSUE) ? '0 : wd_cnt_q + WD_W'(1);
                    if (fire_c) begin
                        if (gnt_q == MST_1) begin
                            m1_ack_o   <= 1'b1;
                            m1_rdata_o <= rsp_rdata_c;
                            m1_err_o   <= rsp_err_c;
                        end else begin
                            m0_ack_o   <= 1'b1;
                            m0_rdata_o <= rsp_rdata_c;
                            m0_err_o   <= rsp_err_c;
                        end
                        if (timeout_c && (to_cnt_q != '1)) begin
                            to_cnt_q <= to_cnt_q + TO_CNT_W'(1);
                        end
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign to_cnt_o = to_cnt_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: table of single transactions plus
// hand-written sequences for arbitration, back-to-back, timeout and reset.
module tb_sys_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic        m0_wen = 1'b0, m0_ren = 1'b0, m1_wen = 1'b0, m1_ren = 1'b0;
    logic [31:0] m0_rdata, m1_rdata, sys_addr, sys_wdata, sys_rdata;
    logic        m0_err, m1_err, m0_ack, m1_ack;
    logic [3:0]  sys_sel;
    logic        sys_wen, sys_ren, sys_err, sys_ack;
    logic [7:0]  to_cnt;

    sys_bus_arbiter #(.TIMEOUT_CYC(16), .AW(32), .DW(32)) dut (
        .sys_clk_i  (clk),
        .sys_rstn_i (rstn),
        .m0_addr_i  (m0_addr),
        .m0_wdata_i (m0_wdata),
        .m0_sel_i   (m0_sel),
        .m0_wen_i   (m0_wen),
        .m0_ren_i   (m0_ren),
        .m0_rdata_o (m0_rdata),
        .m0_err_o   (m0_err),
        .m0_ack_o   (m0_ack),
        .m1_addr_i  (m1_addr),
        .m1_wdata_i (m1_wdata),
        .m1_sel_i   (m1_sel),
        .m1_wen_i   (m1_wen),
        .m1_ren_i   (m1_ren),
        .m1_rdata_o (m1_rdata),
        .m1_err_o   (m1_err),
        .m1_ack_o   (m1_ack),
        .sys_addr_o (sys_addr),
        .sys_wdata_o(sys_wdata),
        .sys_sel_o  (sys_sel),
        .sys_wen_o  (sys_wen),
        .sys_ren_o  (sys_ren),
        .sys_rdata_i(sys_rdata),
        .sys_err_i  (sys_err),
        .sys_ack_i  (sys_ack),
        .to_cnt_o   (to_cnt)
    );

    always #5 clk = ~clk;

    // Slave model: 0x0 acks combinationally, 0x4 acks 4 cycles later, others never.
    logic [31:0] mem0 = 32'h0;
    logic [31:0] reg4 = 32'h12345678;
    int          d4 = 0;

    always_comb begin
        sys_ack   = 1'b0;
        sys_rdata = 32'h0;
        sys_err   = 1'b0;
        if ((sys_wen || sys_ren) && sys_addr == 32'h0) begin
            sys_ack   = 1'b1;
            sys_rdata = mem0;
        end else if (d4 == 1) begin
            sys_ack   = 1'b1;
            sys_rdata = reg4;
        end
    end

    always @(posedge clk) begin
        if (sys_wen && sys_addr == 32'h0) mem0 <= sys_wdata;
        if (sys_wen && sys_addr == 32'h4) reg4 <= sys_wdata;
        if ((sys_wen || sys_ren) && sys_addr == 32'h4) d4 <= 4;
        else if (d4 > 0) d4 <= d4 - 1;
    end

    // Cycle counter and ack monitor.
    int cyc = 0;
    int m0_acks = 0, m1_acks = 0, m0_last = -1, m1_last = -1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (m0_ack) begin m0_acks++; m0_last = cyc; end
        if (m1_ack) begin m1_acks++; m1_last = cyc; end
    end

    int n_cmp = 0, n_bad = 0;
    int pulse_n, issue_cyc, addr_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drive(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_addr = a; m0_wdata = d; m0_sel = 4'hF; m0_wen = wr; m0_ren = !wr;
        end else begin
            m1_addr = a; m1_wdata = d; m1_sel = 4'hF; m1_wen = wr; m1_ren = !wr;
        end
    endtask

    task automatic clear_all();
        m0_wen = 1'b0; m0_ren = 1'b0; m1_wen = 1'b0; m1_ren = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acks"}, {m0_ack, m1_ack, m0_err, m1_err}, 64'h0);
        chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'h0);
        chk({tag, "_sysbus"}, {sys_addr, sys_sel, sys_wen, sys_ren}, 64'h0);
        chk({tag, "_wdata_to"}, {sys_wdata, to_cnt}, 64'h0);
    endtask

    // One transaction from pulse to ack; latency counted in cycles after the pulse cycle.
    task automatic xact(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int budget, output int lat, output logic [31:0] rd, output logic er);
        logic got;
        lat = -1; rd = 'x; er = 1'bx;
        pulse_n = 0; issue_cyc = -1; addr_bad = 0;
        drive(m, wr, a, d);
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (n == 1) clear_all();
            if (sys_wen || sys_ren) begin
                pulse_n++;
                if (issue_cyc < 0) issue_cyc = n;
            end
            got = (m == 0) ? m0_ack : m1_ack;
            if (got) begin
                lat = n;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                er  = (m == 0) ? m0_err : m1_err;
                break;
            end
            if (issue_cyc >= 0 && sys_addr != a) addr_bad++;
        end
    endtask

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [7:0]  exp_to;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          lat, t0, a0, a1;
        logic [31:0] rd;
        logic        er;

        vecs[0] = '{0, 1'b1, 32'h0,  32'h66666666, 1'b0, 32'h0,        1'b0, 3,  8'd0};
        vecs[1] = '{0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h66666666, 1'b0, 3,  8'd0};
        vecs[2] = '{1, 1'b0, 32'h4,  32'h0,        1'b1, 32'h12345678, 1'b0, 7,  8'd0};
        vecs[3] = '{1, 1'b1, 32'h0,  32'hA5A50001, 1'b0, 32'h0,        1'b0, 3,  8'd0};
        vecs[4] = '{1, 1'b0, 32'h0,  32'h0,        1'b1, 32'hA5A50001, 1'b0, 3,  8'd0};
        vecs[5] = '{0, 1'b0, 32'h14, 32'h0,        1'b1, 32'h0,        1'b1, 19, 8'd1};
        vecs[6] = '{0, 1'b0, 32'h4,  32'h0,        1'b1, 32'h12345678, 1'b0, 7,  8'd1};

        do_reset();
        chk_zero("reset");

        // Simultaneous pulses: m0 first; second pair lands in m0's DONE, so m1 goes next.
        a0 = m0_acks; a1 = m1_acks;
        drive(0, 1'b1, 32'h0, 32'h11112222);
        drive(1, 1'b0, 32'h0, 32'h0);
        t0 = cyc;
        tick();
        clear_all();
        wait_cyc(t0 + 3);
        drive(0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 32'h0, 32'h33334444);
        tick();
        clear_all();
        chk("rr_first_m0_ack_cyc", 64'(m0_last - t0), 64'd3);
        chk("rr_first_m1_none", 64'(m1_acks - a1), 64'd0);
        wait_cyc(t0 + 12);
        chk("rr_m1_ack_cyc", 64'(m1_last - t0), 64'd6);
        chk("rr_m0_again_cyc", 64'(m0_last - t0), 64'd9);
        chk("rr_ack_counts", {32'(m0_acks - a0), 32'(m1_acks - a1)}, {32'd2, 32'd1});
        chk("rr_m1_rdata", m1_rdata, 32'h11112222);
        chk("rr_m0_rdata", m0_rdata, 32'h11112222);

        for (int i = 0; i < 7; i++) begin
            xact(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 40, lat, rd, er);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_issue", i), {32'(pulse_n), 32'(issue_cyc)}, {32'd1, 32'd2});
            chk($sformatf("vec%0d_addr_hold", i), 64'(addr_bad), 64'd0);
            chk($sformatf("vec%0d_to_cnt", i), to_cnt, vecs[i].exp_to);
            tick();
        end
        chk("m1_rdata_hold", {m1_rdata, 31'h0, m1_err}, {32'hA5A50001, 32'h0});

        // Watchdog counter saturation.
        for (int i = 0; i < 256; i++) begin
            xact(0, 1'b0, 32'h14, 32'h0, 30, lat, rd, er);
            if (i == 199) chk("to_cnt_mid", to_cnt, 8'd201);
        end
        chk("to_sat_latency", 64'(lat), 64'd19);
        chk("to_sat_resp", {rd, 31'h0, er}, {32'h0, 32'h1});
        chk("to_cnt_sat", to_cnt, 8'd255);
        tick();

        // A pulse while pending is dropped: one ack, and its write never reaches the slave.
        a0 = m0_acks;
        drive(0, 1'b0, 32'h4, 32'h0);
        t0 = cyc;
        tick();
        clear_all();
        wait_cyc(t0 + 2);
        drive(0, 1'b1, 32'h0, 32'hDEADBEEF);
        tick();
        clear_all();
        wait_cyc(t0 + 15);
        chk("pend_drop_acks", 64'(m0_acks - a0), 64'd1);
        chk("pend_drop_ack_cyc", 64'(m0_last - t0), 64'd7);
        chk("pend_drop_rdata", m0_rdata, 32'h12345678);
        xact(0, 1'b0, 32'h0, 32'h0, 40, lat, rd, er);
        chk("pend_drop_mem", rd, 32'hA5A50001);
        tick();

        // Reset during WAIT of a never-acked read abandons it.
        a0 = m0_acks;
        drive(0, 1'b0, 32'h14, 32'h0);
        t0 = cyc;
        tick();
        clear_all();
        wait_cyc(t0 + 6);
        rstn = 1'b0;
        tick();
        chk_zero("midrst");
        rstn = 1'b1;
        repeat (25) tick();
        chk("midrst_no_ack", 64'(m0_acks - a0), 64'd0);
        xact(0, 1'b1, 32'h0, 32'h77778888, 40, lat, rd, er);
        chk("post_rst_wr", {32'(lat), 31'h0, er}, {32'd3, 32'h0});
        tick();
        xact(0, 1'b0, 32'h0, 32'h0, 40, lat, rd, er);
        chk("post_rst_rd", rd, 32'h77778888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
